// File: rtl/clk_div_sched.sv
// Purpose : run-time scheduler for an integer clock divider; produces clk_out/tick
//           and switches divisor or stops only at output-period boundaries.
// Latency : a request transferred at edge E takes effect at the first period
//           boundary at or after E; outputs are registered (one cycle after state).
// Backpressure: cfg_ready_o drops while one accepted request waits for the boundary.
// Ports   : clk_in_i/reset_i    clock and synchronous active-high reset
//           cfg_*_i/cfg_ready_o  divisor/enable request handshake, cfg_err_o reject pulse
//           clk_out_o/tick_o     divided clock and first-cycle-of-period strobe
//           running_o/cur_div_o  divider status and divisor in effect
module clk_div_sched #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 3,
    parameter bit AUTO_START  = 1'b0
) (
    input  logic         clk_in_i,
    input  logic         reset_i,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [W-1:0] cfg_div_i,
    input  logic         cfg_en_i,
    output logic         cfg_err_o,
    output logic         clk_out_o,
    output logic         tick_o,
    output logic         running_o,
    output logic [W-1:0] cur_div_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] TWO     = W'(2);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] cur_div_q, cur_div_d;
    logic         pend_en_q, pend_en_d;
    logic [W-1:0] pend_div_q, pend_div_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         cfg_err_q, cfg_err_d;

    logic accept;
    logic req_ok;
    logic at_end;

    // ceil(n/2) without needing an extra bit: n=2^W-1 gives 2^(W-1), which fits.
    function automatic logic [W-1:0] high_len(input logic [W-1:0] n);
        return (n >> 1) + {{(W-1){1'b0}}, n[0]};
    endfunction

    // State register
    always_ff @(posedge clk_in_i) begin
        if (reset_i) begin
            state_q    <= AUTO_START ? RUN : IDLE;
            // Auto-start parks the counter on the last slot so the first real
            // period begins on the edge after reset is released.
            cnt_q      <= AUTO_START ? (DEF_DIV - ONE) : '0;
            cur_div_q  <= DEF_DIV;
            pend_en_q  <= 1'b0;
            pend_div_q <= '0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_en_q  <= pend_en_d;
            pend_div_q <= pend_div_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        accept     = cfg_valid_i && cfg_ready_o;
        req_ok     = accept && !(cfg_en_i && (cfg_div_i < TWO));
        at_end     = (cnt_q == (cur_div_q - ONE));

        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_en_d  = pend_en_q;
        pend_div_d = pend_div_q;
        // A rejected request only raises the error pulse; the divider keeps going.
        cfg_err_d  = accept && !req_ok;

        unique case (state_q)
            IDLE: begin
                if (req_ok && cfg_en_i) begin
                    state_d   = RUN;
                    cur_div_d = cfg_div_i;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                if (at_end) begin
                    // Request landing on the boundary edge applies immediately.
                    cnt_d = '0;
                    if (req_ok) begin
                        if (cfg_en_i) cur_div_d = cfg_div_i;
                        else          state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (req_ok) begin
                        state_d    = DRAIN;
                        pend_en_d  = cfg_en_i;
                        pend_div_d = cfg_div_i;
                    end
                end
            end
            DRAIN: begin
                if (at_end) begin
                    cnt_d = '0;
                    if (pend_en_q) begin
                        state_d   = RUN;
                        cur_div_d = pend_div_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Waveform is registered from the next counter value so clk_out only
        // changes at c=0 and c=ceil(N/2).
        tick_d    = (state_d != IDLE) && (cnt_d == '0);
        clk_out_d = (state_d != IDLE) && (cnt_d < high_len(cur_div_d));
    end

    // Outputs
    always_comb begin
        cfg_ready_o = (state_q != DRAIN);
        running_o   = (state_q != IDLE);
        cur_div_o   = cur_div_q;
        clk_out_o   = clk_out_q;
        tick_o      = tick_q;
        cfg_err_o   = cfg_err_q;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Run-time controller and scheduler for the integer clock divider.
- Accepts divisor and enable requests over a valid/ready handshake.
- Applies each request only at an output-period boundary, so no runt or stretched pulses appear.
- Generates the divided clock (`clk_out`) plus a per-period `tick` strobe.
- Sits between the config register block and the clock-enable fabric; replaces hard-wired dividers where the ratio must change while running.

Parameters:
- `W`, 8, width of the divisor field.
- `DEFAULT_DIV`, 3, divisor loaded at reset; must be in 2..2^W-1.
- `AUTO_START`, 0, 1 = divider runs from reset with `DEFAULT_DIV`; 0 = stays idle until enabled.

Ports:
- `clk_in`  in  1  sole clock; all logic is posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  request present.
- `cfg_ready`  out  1  controller can accept a request this cycle.
- `cfg_div`  in  W  requested divisor N.
- `cfg_en`  in  1  1 = run with `cfg_div`; 0 = stop (`cfg_div` ignored).
- `cfg_err`  out  1  one-cycle pulse: request rejected.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  high in the first `clk_in` cycle of each output period.
- `running`  out  1  divider active.
- `cur_div`  out  W  divisor currently in effect.

Behaviour:
- States: IDLE, RUN, DRAIN (request pending, waiting for period end).
- Reset (sync, overrides everything, drops any pending request):
  - `clk_out`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=1, `cur_div`=`DEFAULT_DIV`.
  - If `AUTO_START`=1: state=RUN and the first period starts in the cycle after reset deasserts.
  - If `AUTO_START`=0: `running`=0, state=IDLE.
- Handshake:
  - Transfer occurs on an edge with `cfg_valid`=1 and `cfg_ready`=1.
  - `cfg_ready`=1 in IDLE and RUN; 0 in DRAIN.
  - Requester holds `cfg_valid` and payload stable until transfer.
- Validation:
  - `cfg_en`=1 with `cfg_div`<2 is rejected.
  - On rejection: `cfg_err`=1 for exactly the cycle after transfer; no state, counter or `cur_div` change.
  - `cfg_en`=0 is always valid.
- Period generation (RUN/DRAIN):
  - Internal counter c runs 0..N-1 with N=`cur_div`.
  - In the cycle where c=k: `tick`=(k==0) and `clk_out`=(k < ceil(N/2)).
  - Odd N: high ceil(N/2), low floor(N/2) (e.g. N=5 gives 3H/2L). Even N: 50% duty.
- IDLE + valid `cfg_en`=1 accepted at edge E:
  - `cur_div`=N.
  - From cycle E+1: `running`=1, `tick`=1, `clk_out`=1 (period starts).
- IDLE + `cfg_en`=0 accepted: no effect; `cfg_ready` stays 1.
- RUN + valid request accepted at edge E with c≠N-1 before E:
  - Go to DRAIN.
  - Current period completes with the old N.
  - At the boundary edge the request is applied:
    - `cfg_en`=1: `cur_div`=new N, the new period starts with `tick`, state returns to RUN, `cfg_ready`=1 in that tick cycle.
    - `cfg_en`=0: IDLE; `clk_out`=0, `tick`=0, `running`=0, `cfg_ready`=1 from the cycle the next tick would have occurred.
- Simultaneous acceptance and boundary (transfer at the edge ending c=N-1):
  - Request applies at that same boundary; DRAIN is skipped and `cfg_ready` stays 1.
  - Next cycle is the first period with the new N, or IDLE if `cfg_en`=0.
- Same-N request: accepted and applied at the boundary; waveform is unchanged (no phase reset).
- `clk_out` is glitch-free: it never toggles other than at the c=0 and c=ceil(N/2) transitions defined above.
- Max N = 2^W-1; the counter never wraps within a period.

Test Plan:
- AUTO_START=0, reset 1 cycle, then req N=5 `en`=1 -> `tick` every 5 cycles, `clk_out` pattern 11100 repeating, `cur_div`=5, `running`=1 from cycle after transfer.
- Running N=5, req N=4 accepted at c=1 -> `cfg_ready`=0 for cycles c=2..4, then period 1100 with `tick`, `cur_div`=4 in that tick cycle.
- Running N=3, req N=6 accepted exactly at the c=2 edge -> next cycle `tick`=1, pattern 111000, `cfg_ready` never drops.
- Running N=7, req `en`=0 at c=3 -> period finishes 1111000; then `clk_out`=0, `running`=0, `cfg_ready`=1; no further ticks.
- Req N=1 and N=0 (`en`=1) in IDLE and RUN -> `cfg_err` one-cycle pulse each; `cur_div` and waveform unchanged.
- Reset asserted mid-period in DRAIN (pending N=9) -> next cycle all outputs at reset values, `cur_div`=3, pending discarded; with AUTO_START=1 the N=3 pattern 110 resumes after reset.
